ad_wave_rec: RTL



---
 rtl/ad_wave_rec_pkg.sv | 17 +
 rtl/ad_trig_det.sv | 54 +++++
 rtl/ad_wave_rec.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ad_wave_rec_pkg.sv
// Shared constants for the AD9280 waveform recorder: FSM encoding and buffer geometry.
package ad_wave_rec_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 256;
    localparam int ADDR_W    = 8;

    // Address of the final buffer entry; writing it ends a capture.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUF_DEPTH - 1);

endpackage

// File: rtl/ad_trig_det.sv
// Rising-edge trigger detector: holds the previous kept sample, compares it with the
// current one against TRIG_LEVEL and counts kept samples spent waiting in ARM.
module ad_trig_det
    import ad_wave_rec_pkg::*;
#(
    parameter logic [7:0]  TRIG_LEVEL   = 8'd128,
    parameter logic [15:0] TRIG_TIMEOUT = 16'hFFFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,          // accepted start: restart arming
    input  logic       arm,          // FSM is waiting for a trigger
    input  logic       strobe,       // kept-sample strobe
    input  logic [7:0] ad_d1,        // current sample
    output logic       trig_hit,
    output logic       trig_timeout
);

    logic [7:0]  ad_d2;
    logic        primed;
    logic [15:0] to_cnt;
    logic        to_reached;

    // A crossing needs a valid previous sample; the first strobe in ARM only loads ad_d2.
    assign trig_hit     = arm && strobe && primed &&
                          (ad_d2 < TRIG_LEVEL) && (ad_d1 >= TRIG_LEVEL);
    assign to_reached   = (TRIG_TIMEOUT == 16'd0) || (to_cnt == TRIG_TIMEOUT - 16'd1);
    assign trig_timeout = arm && strobe && !trig_hit && to_reached;

    // Previous kept sample, updated on every strobe.
    always_ff @(posedge clk) begin
        if (rst)
            ad_d2 <= '0;
        else if (strobe)
            ad_d2 <= ad_d1;
    end

    // Marks that ad_d2 holds a sample taken since arming.
    always_ff @(posedge clk) begin
        if (rst || clr)
            primed <= 1'b0;
        else if (arm && strobe)
            primed <= 1'b1;
    end

    // Counts strobes spent in ARM; saturates at the timeout point.
    always_ff @(posedge clk) begin
        if (rst || clr)
            to_cnt <= '0;
        else if (arm && strobe && !to_reached)
            to_cnt <= to_cnt + 16'd1;
    end

endmodule

// File: rtl/ad_wave_rec.sv
// AD9280 waveform recorder: decimates the ADC stream, optionally waits for a rising
// edge through TRIG_LEVEL, then writes 256 kept samples into an external buffer RAM.
module ad_wave_rec
    import ad_wave_rec_pkg::*;
#(
    parameter logic [7:0]  SAMPLE_DIV   = 8'd0,
    parameter logic [7:0]  TRIG_LEVEL   = 8'd128,
    parameter logic [15:0] TRIG_TIMEOUT = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              trig_en,
    input  logic [7:0]        ad_data,
    output logic              ad_clk,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              trig_to
);

    state_t            state;
    logic [7:0]        ad_d1;
    logic [7:0]        div_cnt;
    logic [ADDR_W-1:0] sample_cnt;
    logic              strobe;
    logic              start_acc;
    logic              arm;
    logic              trig_hit;
    logic              trig_timeout;

    // ADC is clocked on the opposite edge so ad_data is settled at clk rising edges.
    assign ad_clk    = ~clk;
    assign strobe    = (div_cnt == SAMPLE_DIV);
    assign start_acc = start && (state == IDLE);
    assign arm       = (state == ARM);

    // Capture the ADC output every cycle.
    always_ff @(posedge clk) begin
        if (rst)
            ad_d1 <= '0;
        else
            ad_d1 <= ad_data;
    end

    // Sample-rate divider: strobe on SAMPLE_DIV, realigned by each accepted start.
    always_ff @(posedge clk) begin
        if (rst || start_acc)
            div_cnt <= '0;
        else if (strobe)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 8'd1;
    end

    ad_trig_det #(
        .TRIG_LEVEL   (TRIG_LEVEL),
        .TRIG_TIMEOUT (TRIG_TIMEOUT)
    ) u_trig_det (
        .clk          (clk),
        .rst          (rst),
        .clr          (start_acc),
        .arm          (arm),
        .strobe       (strobe),
        .ad_d1        (ad_d1),
        .trig_hit     (trig_hit),
        .trig_timeout (trig_timeout)
    );

    // Capture sequencer with registered RAM write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            trig_to    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sample_cnt <= '0;
                        trig_to    <= 1'b0;
                        busy       <= 1'b1;
                        state      <= trig_en ? ARM : CAPTURE;
                    end
                end
                ARM: begin
                    // A forced trigger behaves like a real one; only trig_to tells them apart.
                    if (trig_hit || trig_timeout) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= '0;
                        wr_data    <= ad_d1;
                        sample_cnt <= ADDR_W'(1);
                        trig_to    <= trig_timeout;
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (strobe) begin
                        wr_en      <= 1'b1;
                        wr_addr    <= sample_cnt;
                        wr_data    <= ad_d1;
                        sample_cnt <= sample_cnt + ADDR_W'(1);
                        // Stop on the last entry so the count never starts a second pass.
                        if (sample_cnt == LAST_ADDR) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
